onehot_decoder_seq: RTL and testbench

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

---
 rtl/onehot_dec_pkg.sv | 10 +
 rtl/scan_tick_gen.sv | 23 ++
 rtl/onehot_decoder_seq.sv | 84 ++++++++
 tb/tb_onehot_decoder_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared FSM state type and mode encodings
package onehot_dec_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_e;
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: emits one tick every SCAN_DIV enabled cycles, restartable by clr
module scan_tick_gen #(
  parameter int SCAN_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // tick on the last count of a period; clear restarts the period from zero
  always_comb begin
    tick  = en && cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  end
  // divider count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered binary-to-one-hot decoder with free-running scan mode
module onehot_decoder_seq #(
  parameter int IN_W     = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_n,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      in_code,
  output logic                 in_ready,
  output logic [2**IN_W-1:0]   y,
  output logic                 y_valid,
  output logic [IN_W-1:0]      code_out,
  output logic                 wrap
);
  import onehot_dec_pkg::*;
  localparam int OUT_W = 2**IN_W;
  state_e state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic [IN_W-1:0] code_q, code_d;
  logic vld_q, vld_d, wrap_q, wrap_d;
  logic scan_run, tick;
  // scan steps only while already in SCAN and staying there; anything else restarts the divider
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!scan_run),
    .en   (scan_run),
    .tick (tick)
  );
  // next state, handshake and output datapath; entry into a mode is detected by state_q differing
  always_comb begin
    state_d  = en_n ? IDLE : (mode == MODE_SCAN ? SCAN : DECODE);
    in_ready = state_q == DECODE && !en_n && mode == MODE_DECODE;
    scan_run = state_q == SCAN && !en_n && mode == MODE_SCAN;
    y_d      = y_q;
    code_d   = code_q;
    vld_d    = vld_q;
    wrap_d   = 1'b0;
    if (en_n) begin
      y_d   = '0;
      vld_d = 1'b0;
    end else if (mode == MODE_DECODE) begin
      if (state_q != DECODE) begin
        y_d   = '0;
        vld_d = 1'b0;
      end else if (in_valid) begin
        y_d    = OUT_W'(1) << in_code;
        code_d = in_code;
        vld_d  = 1'b1;
      end
    end else if (state_q != SCAN) begin
      y_d    = OUT_W'(1);
      code_d = '0;
      vld_d  = 1'b1;
    end else if (tick) begin
      y_d    = &code_q ? OUT_W'(1) : y_q << 1;
      code_d = code_q + IN_W'(1);
      wrap_d = &code_q;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end
  assign y        = y_q;
  assign y_valid  = vld_q;
  assign code_out = code_q;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: random and directed checks of two decoder configurations against a reference model
module tb_onehot_decoder_seq;
  logic clk = 1'b0, rst_n = 1'b0, en_n = 1'b1, mode = 1'b0, in_valid = 1'b0;
  logic [3:0] in_code = '0;
  logic rdy_a, yv_a, wr_a, rdy_b, yv_b, wr_b;
  logic [15:0] y_a;
  logic [3:0] co_a;
  logic [7:0] y_b;
  logic [2:0] co_b;
  int checks = 0, errors = 0;
  int inw[2] = '{4, 3};
  int dv[2] = '{1, 3};
  int m_st[2], m_code[2], m_cnt[2];
  logic [63:0] m_y[2];
  logic m_vld[2], m_wrap[2];
  always #5 clk = ~clk;
  onehot_decoder_seq #(.IN_W(4), .SCAN_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .in_valid(in_valid),
    .in_code(in_code), .in_ready(rdy_a), .y(y_a), .y_valid(yv_a),
    .code_out(co_a), .wrap(wr_a)
  );
  onehot_decoder_seq #(.IN_W(3), .SCAN_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .in_valid(in_valid),
    .in_code(in_code[2:0]), .in_ready(rdy_b), .y(y_b), .y_valid(yv_b),
    .code_out(co_b), .wrap(wr_b)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_code[k] = 0; m_cnt[k] = 0;
      m_y[k] = '0; m_vld[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask
  function automatic logic model_ready(input int k);
    return rst_n && m_st[k] == 1 && !en_n && !mode;
  endfunction
  // one clock edge of the behavioural model: position is an integer, y is 1 << position
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int ow;
      ow = 1 << inw[k];
      if (en_n) begin
        m_y[k] = '0; m_vld[k] = 1'b0; m_wrap[k] = 1'b0; m_cnt[k] = 0; m_st[k] = 0;
      end else if (!mode) begin
        if (m_st[k] == 1 && in_valid) begin
          m_code[k] = int'(in_code) % ow;
          m_y[k] = 64'd1 << m_code[k];
          m_vld[k] = 1'b1;
        end else if (m_st[k] != 1) begin
          m_y[k] = '0; m_vld[k] = 1'b0;
        end
        m_wrap[k] = 1'b0; m_cnt[k] = 0; m_st[k] = 1;
      end else begin
        m_wrap[k] = 1'b0;
        if (m_st[k] != 2) begin
          m_code[k] = 0; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == dv[k]) begin
            m_cnt[k] = 0;
            m_code[k] = (m_code[k] + 1) % ow;
            m_wrap[k] = m_code[k] == 0;
          end
        end
        m_y[k] = 64'd1 << m_code[k];
        m_vld[k] = 1'b1; m_st[k] = 2;
      end
    end
  endtask
  task automatic check_all();
    chk("y_a", 64'(y_a), m_y[0]);
    chk("code_a", 64'(co_a), 64'(m_code[0]));
    chk("valid_a", 64'(yv_a), 64'(m_vld[0]));
    chk("wrap_a", 64'(wr_a), 64'(m_wrap[0]));
    chk("onehot_a", 64'($onehot0(y_a)), 64'd1);
    chk("vcons_a", 64'(yv_a), 64'(y_a != 0));
    chk("y_b", 64'(y_b), m_y[1]);
    chk("code_b", 64'(co_b), 64'(m_code[1]));
    chk("valid_b", 64'(yv_b), 64'(m_vld[1]));
    chk("wrap_b", 64'(wr_b), 64'(m_wrap[1]));
    chk("onehot_b", 64'($onehot0(y_b)), 64'd1);
    chk("vcons_b", 64'(yv_b), 64'(y_b != 0));
  endtask
  task automatic cyc(input logic e, input logic m, input logic v, input logic [3:0] c);
    en_n = e; mode = m; in_valid = v; in_code = c;
    #1;
    chk("ready_a", 64'(rdy_a), 64'(model_ready(0)));
    chk("ready_b", 64'(rdy_b), 64'(model_ready(1)));
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("ready_a_rst", 64'(rdy_a), 64'd0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    int w_a, wb1, wb2;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'hB);
    chk("dec_b_y", 64'(y_a), 64'h0800);
    chk("dec_b_code", 64'(co_a), 64'd11);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h2);
    chk("dec_hold_y", 64'(y_a), 64'h0800);
    w_a = 0; wb1 = -1; wb2 = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'b1, 1'($urandom), 4'($urandom));
      if (i < 20 && wr_a) w_a++;
      if (wr_b) begin
        if (wb1 < 0) wb1 = i;
        else if (wb2 < 0) wb2 = i;
      end
    end
    chk("wrap_cnt_a", 64'(w_a), 64'd1);
    chk("wrap_first_b", 64'(wb1), 64'd24);
    chk("wrap_period_b", 64'(wb2 - wb1), 64'd24);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'h3);
    chk("dec_3_y", 64'(y_a), 64'h0008);
    cyc(1'b1, 1'b0, 1'b1, 4'h5);
    chk("drop_y", 64'(y_a), 64'h0);
    chk("drop_valid", 64'(yv_a), 64'd0);
    chk("drop_code", 64'(co_a), 64'd3);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("scan_pos6", 64'(y_a), 64'h0040);
    rst_pulse();
    chk("rst_y_now", 64'(y_a), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("scan_restart", 64'(y_a), 64'h0001);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) rst_pulse();
      else cyc($urandom_range(0, 7) == 0, ($urandom_range(0, 5) == 0) ? ~mode : mode,
               1'($urandom), 4'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
